// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   md_op_e      : funct3 encoding of the M-extension operations
//   md_state_e   : sequencing states of md_unit
//   XLEN_MIN_NEG : most negative XLEN-bit value, the signed-overflow dividend
//   is_div / a_is_signed / b_is_signed : operation classification helpers
package rv32m_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] XLEN_MIN_NEG = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic is_div(md_op_e op);
    return op[2];
  endfunction

  // MUL works on raw bits: the low product word does not depend on signedness.
  function automatic logic a_is_signed(md_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_is_signed(md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/md_divider_core.sv
// Restoring divider datapath, one quotient bit per step on unsigned magnitudes.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load          : capture dividend/divisor and clear the partial remainder
//   step          : perform one restoring step
//   dividend      : unsigned dividend
//   divisor       : unsigned divisor (nonzero whenever steps are issued)
//   quotient      : quotient after XLEN steps
//   remainder     : remainder after XLEN steps
module md_divider_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  // The quotient register starts as the dividend; each step shifts one dividend
  // bit out of the top into the partial remainder and one quotient bit in below.
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   partial;
  logic [XLEN:0]   trial;

  always_comb begin
    partial = {rem_q, quo_q[XLEN-1]};
    // Bit XLEN of the difference is the borrow: set means "restore".
    trial   = partial - {1'b0, dvs_q};
  end

  // NOTE: datapath registers are reset too, so the unit comes up in a known
  // state after an asynchronous reset rather than carrying stale partial results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= trial[XLEN] ? partial[XLEN-1:0] : trial[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit producing a register-file write.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   start_i           : request, sampled only while idle
//   funct3_i          : M-extension operation (md_op_e)
//   rs1_data_i        : operand A (multiplicand / dividend)
//   rs2_data_i        : operand B (multiplier / divisor)
//   rd_addr_i         : destination register
//   kill_i            : abort the in-flight operation
//   busy_o            : operation in flight (accept edge through DONE)
//   done_o            : one-cycle completion pulse
//   rd_wren_o         : register-file write enable (suppressed for x0)
//   rd_addr_o         : destination of the last completed operation
//   rd_data_o         : result of the last completed operation
module md_unit
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_wren_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int unsigned     CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = XLEN_MIN_NEG;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  md_op_e            op_q;
  md_op_e            op_in;
  logic [4:0]        addr_q;
  logic              neg_a_q, neg_b_q;
  logic              dz_q, ovf_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rd_data_q;
  logic [4:0]        rd_addr_q;

  logic              accept;
  logic              neg_a_in, neg_b_in;
  logic              dz_in, ovf_in;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   quo, rem;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, a_orig;
  logic [XLEN-1:0]   fix_result;

  // ---------------------------------------------------------------- operand decode
  assign op_in  = md_op_e'(funct3_i);
  assign accept = (state_q == ST_IDLE) && start_i;

  always_comb begin
    neg_a_in = a_is_signed(op_in) && rs1_data_i[XLEN-1];
    neg_b_in = b_is_signed(op_in) && rs2_data_i[XLEN-1];
    mag_a_in = neg_a_in ? -rs1_data_i : rs1_data_i;
    mag_b_in = neg_b_in ? -rs2_data_i : rs2_data_i;
    dz_in    = is_div(op_in) && (rs2_data_i == '0);
    ovf_in   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (rs1_data_i == MIN_NEG) && (rs2_data_i == {XLEN{1'b1}});
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = (dz_in || ovf_in) ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A flush wins over everything once an operation is in flight.
    if (kill_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // ---------------------------------------------------------------- datapath
  // Shift-add: the low half of prod_q starts as the multiplier and is consumed
  // LSB first while the running sum enters from the top.
  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                   (prod_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      addr_q    <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      mag_a_q   <= '0;
      prod_q    <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        op_q    <= op_in;
        addr_q  <= rd_addr_i;
        neg_a_q <= neg_a_in;
        neg_b_q <= neg_b_in;
        dz_q    <= dz_in;
        ovf_q   <= ovf_in;
        mag_a_q <= mag_a_in;
        prod_q  <= {{XLEN{1'b0}}, mag_b_in};
      end else if (state_q == ST_CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!is_div(op_q)) prod_q <= {mul_sum, prod_q[XLEN-1:1]};
      end
      // Results are published only by a FIX that is not being flushed.
      if ((state_q == ST_FIX) && !kill_i) begin
        rd_data_q <= fix_result;
        rd_addr_q <= addr_q;
      end
    end
  end

  md_divider_core #(
    .XLEN (XLEN)
  ) u_div (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load      (accept),
    .step      ((state_q == ST_CALC) && is_div(op_q)),
    .dividend  (mag_a_in),
    .divisor   (mag_b_in),
    .quotient  (quo),
    .remainder (rem)
  );

  // ---------------------------------------------------------------- sign fix / select
  always_comb begin
    prod_fix   = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
    quo_fix    = (neg_a_q ^ neg_b_q) ? -quo : quo;
    rem_fix    = neg_a_q ? -rem : rem;
    // Original A rebuilt from its magnitude, for the remainder-by-zero case.
    a_orig     = neg_a_q ? -mag_a_q : mag_a_q;
    fix_result = '0;
    unique case (op_q)
      OP_MUL:                       fix_result = prod_q[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result = dz_q  ? {XLEN{1'b1}} :
                                                 ovf_q ? MIN_NEG : quo_fix;
      OP_REM, OP_REMU:              fix_result = dz_q  ? a_orig :
                                                 ovf_q ? '0 : rem_fix;
      default:                      fix_result = '0;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE) && !kill_i;
  assign rd_wren_o = done_o && (rd_addr_q != 5'd0);
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed literal cases plus randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd_addr = '0;
  logic        kill = 1'b0;
  logic        busy_o, done_o, rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int checks = 0;
  int errors = 0;

  md_unit dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start),
    .funct3_i   (funct3),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .rd_addr_i  (rd_addr),
    .kill_i     (kill),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_wren_o  (rd_wren_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the start-sampling cycle to the done cycle.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0)) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // ---------------------------------------------------------------- compare process
  int          m_cyc = 0;
  logic        m_busy = 1'b0;
  int          m_done_cyc = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_addr = '0;
  logic [31:0] e_data = '0;
  logic [4:0]  e_addr = '0;
  logic        e_done;

  initial begin : compare
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!rst_ni) begin
        m_busy = 1'b0;
        e_data = '0;
        e_addr = '0;
        e_done = 1'b0;
      end else begin
        if (m_busy && m_cyc == m_done_cyc) begin
          e_data = m_res;
          e_addr = m_addr;
        end
        e_done = m_busy && (m_cyc == m_done_cyc) && !kill;
      end
      check("busy", busy_o, m_busy);
      check("done", done_o, e_done);
      check("wren", rd_wren_o, e_done && (m_addr != 0));
      check("rd_data", rd_data_o, e_data);
      check("rd_addr", rd_addr_o, e_addr);
      if (rst_ni) begin
        if (m_busy) begin
          if (kill || m_cyc == m_done_cyc) m_busy = 1'b0;
        end else if (start) begin
          m_busy     = 1'b1;
          m_done_cyc = m_cyc + ref_latency(funct3, rs1, rs2);
          m_res      = ref_result(funct3, rs1, rs2);
          m_addr     = rd_addr;
        end
      end
    end
  end

  // ---------------------------------------------------------------- directed helpers
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] data,
                        output logic wren, output int lat);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_addr = rd;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 1;
    data = '0;
    wren = 1'b0;
    forever begin
      @(negedge clk);
      if (done_o) begin
        data = rd_data_o;
        wren = rd_wren_o;
        break;
      end
      lat++;
      if (lat > 60) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic op_check(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] d;
    logic        w;
    int          l;
    run_op(f, a, b, 5'd1, d, w, l);
    check({name, "_data"}, d, exp);
    check({name, "_lat"}, l, exp_lat);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------- main sequence
  logic [31:0] d;
  logic        w;
  int          l;
  int          n, n_done, first_done, second_done;

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_wren", rd_wren_o, 1'b0);
    check("reset_data", rd_data_o, 32'd0);
    check("reset_addr", rd_addr_o, 5'd0);
    rst_ni = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, d, w, l);
    check("mul_data", d, 32'hFFFF_FFEB);
    check("mul_lat", l, 34);
    check("mul_wren", w, 1'b1);
    check("mul_addr", rd_addr_o, 5'd5);

    op_check("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    op_check("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    op_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    op_check("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    op_check("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    op_check("divu",   3'd5, 32'd100, 32'd7, 32'd14, 34);
    op_check("remu",   3'd7, 32'd100, 32'd7, 32'd2, 34);
    op_check("div_z",  3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    op_check("rem_z",  3'd6, 32'd5, 32'd0, 32'd5, 2);
    op_check("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    op_check("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

    run_op(3'd0, 32'd3, 32'd4, 5'd0, d, w, l);
    check("x0_data", d, 32'd12);
    check("x0_lat", l, 34);
    check("x0_wren", w, 1'b0);

    // start held through busy: one op per accept, re-accept right after DONE
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7; rd_addr = 5'd1;
    n = 0; n_done = 0; first_done = -1; second_done = -1;
    while (n_done < 2 && n < 200) begin
      @(negedge clk);
      if (done_o) begin
        if (n_done == 0) first_done = n;
        else second_done = n;
        n_done++;
      end
      n++;
    end
    #1 start = 1'b0;
    check("held_first", first_done, 34);
    check("held_second", second_done, 69);

    // kill at CALC cycle 10
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd_addr = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", busy_o, 1'b0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o || rd_wren_o) n_done++;
    end
    check("kill_no_done", n_done, 0);

    // asynchronous reset during CALC
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd_addr = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_done", done_o, 1'b0);
    check("arst_wren", rd_wren_o, 1'b0);
    check("arst_data", rd_data_o, 32'd0);
    check("arst_addr", rd_addr_o, 5'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    op_check("divu_after_rst", 3'd5, 32'd9, 32'd3, 32'd3, 34);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start   = 1'($urandom_range(0, 1));
      funct3  = 3'($urandom_range(0, 7));
      rs1     = rand_operand();
      rs2     = rand_operand();
      rd_addr = 5'($urandom_range(0, 31));
      kill    = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    kill  = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
